// File: rtl/ccip_mmio_requester_pkg.sv
// Shared types for the CCI-P MMIO requester: FSM states, MMIO constants and the
// reduced t_if_ccip_Rx / t_if_ccip_Tx bundles seen on the AFU boundary.
package ccip_mmio_req_pkg;

  typedef enum logic [2:0] {IDLE, WR_ISSUE, RD_ISSUE, WAIT_RSP, RSP} t_mmio_req_state;

  localparam logic [1:0]  MMIO_LEN_8B   = 2'b01;
  localparam logic [15:0] MMIO_ADDR_DFH = 16'h0000;
  localparam logic [15:0] AFU_ID_L      = 16'h0002;
  localparam logic [15:0] AFU_ID_H      = 16'h0004;
  localparam logic [15:0] USER_REG      = 16'h0020;

  typedef logic [8:0] t_ccip_tid;

  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    t_ccip_tid   tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [511:0]        data;
    logic                rspValid;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [27:0] hdr;
    logic        rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  // Request channels c0/c1 are reduced to their valid bits; only c2 matters here.
  typedef struct packed {
    logic           c0Valid;
    logic           c1Valid;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

  function automatic t_ccip_c0_ReqMmioHdr mmio_hdr(input logic [15:0] addr, input t_ccip_tid tid);
    t_ccip_c0_ReqMmioHdr h;
    h.address = addr;
    h.length  = MMIO_LEN_8B;
    h.rsvd    = 1'b0;
    h.tid     = tid;
    return h;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && !(&v)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/ccip_mmio_requester_if.sv
// Command/response handshake between a command source and the MMIO requester.
interface ccip_mmio_requester_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_timeout;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout
  );
endinterface

// File: rtl/ccip_mmio_requester.sv
// Host-side CCI-P MMIO master: posted writes, one outstanding read with tid match and timeout.
// Define MMIO_REQ_STATS_EN to add saturating wr/rd/timeout/tid-error counters.
module ccip_mmio_requester
  import ccip_mmio_req_pkg::*;
#(
  parameter int             TIMEOUT_CYCLES = 256,
  parameter logic [8:0]     TID_INIT       = 9'd0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ccip_mmio_requester_if.slave        cmd_if,
  output t_if_ccip_Rx                 rx_out,
  input  t_if_ccip_Tx                 tx_in
`ifdef MMIO_REQ_STATS_EN
  ,
  output logic [31:0]                 stat_wr,
  output logic [31:0]                 stat_rd,
  output logic [31:0]                 stat_timeout,
  output logic [31:0]                 stat_tid_err
`endif
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  t_mmio_req_state state_q, state_d;
  t_ccip_tid       tid_q, tid_d, pend_q, pend_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [63:0]     rsp_data_q, rsp_data_d;
  logic            rsp_to_q, rsp_to_d;
  t_if_ccip_Rx     rx_q, rx_d;
  logic            match, to_hit;

  assign match  = tx_in.c2.mmioRdValid && (tx_in.c2.hdr.tid == pend_q);
  assign to_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    tid_d       = tid_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_to_d    = rsp_to_q;
    rx_d        = '0;
    unique case (state_q)
      IDLE: if (cmd_if.cmd_valid && cmd_ready_q) begin
        rx_d.c0.hdr = mmio_hdr(cmd_if.cmd_addr, tid_q);
        if (cmd_if.cmd_write) begin
          rx_d.c0.data[63:0]  = cmd_if.cmd_wdata;
          rx_d.c0.mmioWrValid = 1'b1;
          state_d             = WR_ISSUE;
        end else begin
          rx_d.c0.mmioRdValid = 1'b1;
          pend_d              = tid_q;
          tid_d               = tid_q + 9'd1;
          state_d             = RD_ISSUE;
        end
      end
      WR_ISSUE: state_d = IDLE;
      RD_ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_RSP;
      end
      // A match in the final wait cycle still beats the timeout.
      WAIT_RSP: begin
        cnt_d = cnt_q + CW'(1);
        if (match) begin
          rsp_data_d  = tx_in.c2.data;
          rsp_to_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else if (to_hit) begin
          rsp_data_d  = '0;
          rsp_to_d    = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: if (cmd_if.rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tid_q       <= TID_INIT;
      pend_q      <= TID_INIT;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_to_q    <= 1'b0;
      rx_q        <= '0;
    end else begin
      state_q     <= state_d;
      tid_q       <= tid_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_to_q    <= rsp_to_d;
      rx_q        <= rx_d;
    end
  end

  assign cmd_if.cmd_ready   = cmd_ready_q;
  assign cmd_if.rsp_valid   = rsp_valid_q;
  assign cmd_if.rsp_data    = rsp_data_q;
  assign cmd_if.rsp_timeout = rsp_to_q;
  assign rx_out             = rx_q;

  logic unused_tx;
  assign unused_tx = ^{tx_in.c0Valid, tx_in.c1Valid};

`ifdef MMIO_REQ_STATS_EN
  logic [31:0] st_wr_q, st_rd_q, st_to_q, st_err_q;
  logic        in_wait;
  assign in_wait = (state_q == WAIT_RSP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_wr_q  <= '0;
      st_rd_q  <= '0;
      st_to_q  <= '0;
      st_err_q <= '0;
    end else begin
      st_wr_q  <= sat_inc(st_wr_q,  state_q == WR_ISSUE);
      st_rd_q  <= sat_inc(st_rd_q,  state_q == RD_ISSUE);
      st_to_q  <= sat_inc(st_to_q,  in_wait && !match && to_hit);
      st_err_q <= sat_inc(st_err_q, in_wait && tx_in.c2.mmioRdValid && !match);
    end
  end

  assign stat_wr      = st_wr_q;
  assign stat_rd      = st_rd_q;
  assign stat_timeout = st_to_q;
  assign stat_tid_err = st_err_q;
`endif

endmodule

// File: tb/tb_ccip_mmio_requester.sv
// Randomized self-checking bench for ccip_mmio_requester against a transaction-level model.
module tb_ccip_mmio_requester;
  import ccip_mmio_req_pkg::*;

  localparam int         T    = 16;
  localparam logic [8:0] TID0 = 9'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ccip_mmio_requester_if cif();
  t_if_ccip_Rx rx_out;
  t_if_ccip_Tx tx_in;
`ifdef MMIO_REQ_STATS_EN
  logic [31:0] stat_wr, stat_rd, stat_timeout, stat_tid_err;
`endif

  ccip_mmio_requester #(.TIMEOUT_CYCLES(T), .TID_INIT(TID0)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_if(cif.slave), .rx_out(rx_out), .tx_in(tx_in)
`ifdef MMIO_REQ_STATS_EN
    , .stat_wr(stat_wr), .stat_rd(stat_rd), .stat_timeout(stat_timeout), .stat_tid_err(stat_tid_err)
`endif
  );

  int errors = 0, checks = 0;
  // Model state: next tid and expected statistics
  int m_tid, m_wr, m_rd, m_to, m_err;

  // Observations from the drivers
  logic        w_pulse, w_hi_zero, w_rdy;
  logic [15:0] w_addr;
  logic [1:0]  w_len;
  logic [8:0]  w_tid;
  logic [63:0] w_lo;
  logic [1:0]  w_after;
  logic        o_pulse, o_to, o_stable;
  logic [15:0] o_addr;
  logic [1:0]  o_len;
  logic [8:0]  o_tid;
  logic [63:0] o_data;
  int          o_wait;
  logic [1:0]  o_after;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [63:0] data);
    cif.cmd_valid = 1'b1; cif.cmd_write = 1'b1; cif.cmd_addr = addr; cif.cmd_wdata = data;
    tick();
    cif.cmd_valid = 1'b0; cif.cmd_write = 1'b0;
    w_pulse   = rx_out.c0.mmioWrValid && !rx_out.c0.mmioRdValid;
    w_addr    = rx_out.c0.hdr.address;
    w_len     = rx_out.c0.hdr.length;
    w_tid     = rx_out.c0.hdr.tid;
    w_lo      = rx_out.c0.data[63:0];
    w_hi_zero = (rx_out.c0.data[511:64] == '0);
    w_rdy     = cif.cmd_ready;
    tick();
    w_after = {rx_out.c0.mmioWrValid, cif.cmd_ready};
  endtask

  // reply_k / wrong_k: wait cycle (1-based) in which a matching / wrong-tid completion is driven; 0 = none
  task automatic do_read(input logic [15:0] addr, input int reply_k, input int wrong_k,
                         input logic [63:0] data, input int hold, input bit noise);
    cif.cmd_valid = 1'b1; cif.cmd_write = 1'b0; cif.cmd_addr = addr;
    tick();
    cif.cmd_valid = 1'b0;
    o_pulse = rx_out.c0.mmioRdValid && !rx_out.c0.mmioWrValid;
    o_addr  = rx_out.c0.hdr.address;
    o_len   = rx_out.c0.hdr.length;
    o_tid   = rx_out.c0.hdr.tid;
    if (noise) begin
      tx_in.c2.mmioRdValid = 1'b1; tx_in.c2.hdr.tid = o_tid; tx_in.c2.data = ~data;
    end
    tick();
    tx_in.c2 = '0;
    if (rx_out.c0.mmioRdValid) o_pulse = 1'b0;
    o_wait = 0;
    for (int k = 1; k <= T + 4 && o_wait == 0; k++) begin
      if (k == reply_k) begin
        tx_in.c2.mmioRdValid = 1'b1; tx_in.c2.hdr.tid = o_tid; tx_in.c2.data = data;
      end else if (k == wrong_k) begin
        tx_in.c2.mmioRdValid = 1'b1;
        tx_in.c2.hdr.tid = 9'(o_tid + 9'd1 + 9'($urandom_range(0, 510)));
        tx_in.c2.data = {$urandom, $urandom};
      end
      tick();
      tx_in.c2 = '0;
      if (cif.rsp_valid) o_wait = k;
    end
    o_data = cif.rsp_data;
    o_to   = cif.rsp_timeout;
    o_stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (!(cif.rsp_valid && cif.rsp_data === o_data && cif.rsp_timeout === o_to && !cif.cmd_ready))
        o_stable = 1'b0;
    end
    cif.rsp_ready = 1'b1;
    tick();
    cif.rsp_ready = 1'b0;
    o_after = {cif.rsp_valid, cif.cmd_ready};
  endtask

  // Model: a reply inside the window is returned, otherwise a timeout after exactly T wait cycles
  function automatic int exp_wait(input int reply_k);
    return (reply_k >= 1 && reply_k <= T) ? reply_k : T;
  endfunction

  task automatic model_read(input int reply_k, input int wrong_k);
    m_tid = (m_tid + 1) % 512;
    m_rd++;
    if (reply_k < 1 || reply_k > T) m_to++;
    if (wrong_k >= 1 && wrong_k <= exp_wait(reply_k)) m_err++;
  endtask

  task automatic model_reset();
    m_tid = int'(TID0); m_wr = 0; m_rd = 0; m_to = 0; m_err = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    model_reset();
    checks++; if (cif.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b want 1", cif.cmd_ready); end
    checks++; if (cif.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", cif.rsp_valid); end
    checks++; if (cif.rsp_data !== 64'd0 || cif.rsp_timeout !== 1'b0) begin errors++; $display("FAIL rst_rsp: got %h/%b want 0/0", cif.rsp_data, cif.rsp_timeout); end
    checks++; if (rx_out !== '0) begin errors++; $display("FAIL rst_rx_out: got nonzero want 0"); end
    rst_n = 1'b1;
    tick();
    checks++; if (cif.cmd_ready !== 1'b1 || rx_out !== '0) begin errors++; $display("FAIL rst_idle: got ready=%b want 1 with quiet rx", cif.cmd_ready); end
  endtask

  task automatic test_write();
    do_write(USER_REG, 64'hDEAD_BEEF);
    m_wr++;
    checks++; if (w_pulse !== 1'b1) begin errors++; $display("FAIL wr_pulse: got %b want 1", w_pulse); end
    checks++; if (w_addr !== USER_REG || w_len !== 2'b01) begin errors++; $display("FAIL wr_hdr: got %h/%b want 0020/01", w_addr, w_len); end
    checks++; if (w_tid !== 9'(m_tid)) begin errors++; $display("FAIL wr_tid: got %0d want %0d", w_tid, m_tid); end
    checks++; if (w_lo !== 64'hDEAD_BEEF || w_hi_zero !== 1'b1) begin errors++; $display("FAIL wr_data: got %h hi0=%b want deadbeef hi0=1", w_lo, w_hi_zero); end
    checks++; if (w_rdy !== 1'b0 || w_after !== 2'b01) begin errors++; $display("FAIL wr_ready_pulse: got rdy=%b after=%b want 0/01", w_rdy, w_after); end
  endtask

  task automatic test_read_basic();
    logic [8:0] t;
    t = 9'(m_tid);
    do_read(MMIO_ADDR_DFH, 3, 0, 64'h1000_0100_0000_0000, 0, 1'b0);
    model_read(3, 0);
    checks++; if (o_pulse !== 1'b1 || o_addr !== MMIO_ADDR_DFH || o_len !== 2'b01) begin errors++; $display("FAIL rd_issue: got p=%b a=%h l=%b want 1/0000/01", o_pulse, o_addr, o_len); end
    checks++; if (o_tid !== t) begin errors++; $display("FAIL rd_tid: got %0d want %0d", o_tid, t); end
    checks++; if (o_wait !== 3) begin errors++; $display("FAIL rd_latency: got %0d want 3", o_wait); end
    checks++; if (o_data !== 64'h1000_0100_0000_0000 || o_to !== 1'b0) begin errors++; $display("FAIL rd_data: got %h/%b want 1000010000000000/0", o_data, o_to); end
    checks++; if (o_after !== 2'b01) begin errors++; $display("FAIL rd_release: got %b want 01", o_after); end
  endtask

  task automatic test_wrong_tid();
    do_read(AFU_ID_L, 4, 2, 64'hA5A5_0000_1234_5678, 0, 1'b0);
    model_read(4, 2);
    checks++; if (o_wait !== 4 || o_data !== 64'hA5A5_0000_1234_5678 || o_to !== 1'b0) begin errors++; $display("FAIL wrong_tid: got k=%0d d=%h to=%b want 4/a5a5000012345678/0", o_wait, o_data, o_to); end
`ifdef MMIO_REQ_STATS_EN
    checks++; if (stat_tid_err !== 32'(m_err)) begin errors++; $display("FAIL stat_tid_err: got %0d want %0d", stat_tid_err, m_err); end
`endif
  endtask

  task automatic test_timeout();
    logic [8:0] old;
    old = 9'(m_tid);
    do_read(AFU_ID_H, 0, 0, 64'h1111_2222_3333_4444, 0, 1'b1);
    model_read(0, 0);
    checks++; if (o_wait !== T || o_to !== 1'b1 || o_data !== 64'd0) begin errors++; $display("FAIL timeout: got k=%0d to=%b d=%h want %0d/1/0", o_wait, o_to, o_data, T); end
    tx_in.c2.mmioRdValid = 1'b1; tx_in.c2.hdr.tid = old; tx_in.c2.data = 64'hBAD;
    tick();
    tx_in.c2 = '0;
    checks++; if (cif.rsp_valid !== 1'b0 || cif.cmd_ready !== 1'b1) begin errors++; $display("FAIL late_reply: got v=%b r=%b want 0/1", cif.rsp_valid, cif.cmd_ready); end
    do_read(USER_REG, 2, 0, 64'h5555_6666_7777_8888, 0, 1'b0);
    model_read(2, 0);
    checks++; if (o_tid !== 9'(old + 9'd1) || o_data !== 64'h5555_6666_7777_8888) begin errors++; $display("FAIL post_timeout: got tid=%0d d=%h want %0d/5555666677778888", o_tid, o_data, old + 9'd1); end
`ifdef MMIO_REQ_STATS_EN
    checks++; if (stat_timeout !== 32'(m_to)) begin errors++; $display("FAIL stat_timeout: got %0d want %0d", stat_timeout, m_to); end
`endif
  endtask

  task automatic test_rsp_hold();
    do_read(USER_REG, 1, 0, 64'hCAFE_F00D_0BAD_BEEF, 5, 1'b0);
    model_read(1, 0);
    checks++; if (o_stable !== 1'b1 || o_data !== 64'hCAFE_F00D_0BAD_BEEF) begin errors++; $display("FAIL rsp_hold: got stable=%b d=%h want 1/cafef00d0badbeef", o_stable, o_data); end
    checks++; if (o_after !== 2'b01) begin errors++; $display("FAIL hold_release: got %b want 01", o_after); end
  endtask

  task automatic test_reset_mid_read();
    logic [8:0] old;
    cif.cmd_valid = 1'b1; cif.cmd_write = 1'b0; cif.cmd_addr = USER_REG;
    tick();
    cif.cmd_valid = 1'b0;
    old = rx_out.c0.hdr.tid;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    model_reset();
    checks++; if (cif.cmd_ready !== 1'b1 || cif.rsp_valid !== 1'b0 || cif.rsp_data !== 64'd0 || cif.rsp_timeout !== 1'b0 || rx_out !== '0)
      begin errors++; $display("FAIL mid_reset: got r=%b v=%b d=%h to=%b want 1/0/0/0", cif.cmd_ready, cif.rsp_valid, cif.rsp_data, cif.rsp_timeout); end
`ifdef MMIO_REQ_STATS_EN
    checks++; if ({stat_wr, stat_rd, stat_timeout, stat_tid_err} !== '0) begin errors++; $display("FAIL stat_reset: got %0d/%0d/%0d/%0d want 0", stat_wr, stat_rd, stat_timeout, stat_tid_err); end
`endif
    rst_n = 1'b1;
    tx_in.c2.mmioRdValid = 1'b1; tx_in.c2.hdr.tid = old; tx_in.c2.data = 64'hBAD;
    tick();
    tx_in.c2 = '0;
    checks++; if (cif.rsp_valid !== 1'b0) begin errors++; $display("FAIL post_reset_cpl: got %b want 0", cif.rsp_valid); end
    do_read(AFU_ID_L, 5, 0, 64'h0123_4567_89AB_CDEF, 0, 1'b0);
    model_read(5, 0);
    checks++; if (o_tid !== TID0 || o_data !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL reset_tid: got tid=%0d d=%h want %0d/0123456789abcdef", o_tid, o_data, TID0); end
  endtask

  task automatic test_random();
    int reply_k, wrong_k, ek;
    logic [63:0] d;
    logic [15:0] a;
    for (int i = 0; i < 600; i++) begin
      d = {$urandom, $urandom};
      a = 16'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        do_write(a, d);
        m_wr++;
        checks++; if (w_pulse !== 1'b1 || w_addr !== a || w_lo !== d || w_tid !== 9'(m_tid) || w_after !== 2'b01)
          begin errors++; $display("FAIL rnd_wr %0d: got p=%b a=%h d=%h tid=%0d want 1/%h/%h/%0d", i, w_pulse, w_addr, w_lo, w_tid, a, d, m_tid); end
      end else begin
        reply_k = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, T + 2));
        wrong_k = int'($urandom_range(0, T));
        if (wrong_k == reply_k) wrong_k = 0;
        ek = exp_wait(reply_k);
        checks++; if (cif.cmd_ready !== 1'b1) begin errors++; $display("FAIL rnd_idle %0d: got %b want 1", i, cif.cmd_ready); end
        checks++; if (9'(m_tid) !== TID0 + 9'(m_rd)) begin errors++; $display("FAIL rnd_model %0d", i); end
        do_read(a, reply_k, wrong_k, d, int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
        checks++; if (o_pulse !== 1'b1 || o_addr !== a || o_tid !== 9'(m_tid))
          begin errors++; $display("FAIL rnd_rd_issue %0d: got p=%b a=%h tid=%0d want 1/%h/%0d", i, o_pulse, o_addr, o_tid, a, m_tid); end
        model_read(reply_k, wrong_k);
        checks++; if (o_wait !== ek || o_to !== (reply_k < 1 || reply_k > T) || o_data !== ((reply_k >= 1 && reply_k <= T) ? d : 64'd0))
          begin errors++; $display("FAIL rnd_rsp %0d: got k=%0d to=%b d=%h want k=%0d reply=%0d d=%h", i, o_wait, o_to, o_data, ek, reply_k, d); end
        checks++; if (o_stable !== 1'b1 || o_after !== 2'b01) begin errors++; $display("FAIL rnd_hold %0d: got s=%b a=%b want 1/01", i, o_stable, o_after); end
      end
    end
`ifdef MMIO_REQ_STATS_EN
    checks++; if (stat_wr !== 32'(m_wr) || stat_rd !== 32'(m_rd) || stat_timeout !== 32'(m_to) || stat_tid_err !== 32'(m_err))
      begin errors++; $display("FAIL rnd_stats: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", stat_wr, stat_rd, stat_timeout, stat_tid_err, m_wr, m_rd, m_to, m_err); end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cif.cmd_valid = 1'b0; cif.cmd_write = 1'b0; cif.cmd_addr = '0; cif.cmd_wdata = '0; cif.rsp_ready = 1'b0;
    tx_in = '0;
    model_reset();
    test_reset();
    test_write();
    test_read_basic();
    test_wrong_tid();
    test_timeout();
    test_rsp_hold();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
